// File: rtl/alu_pkg.sv
// alu_pkg: shared types for the execute-stage ALU and the sequential multiplier.
// Operation select encodings, output mux selects and multiplier FSM states.
package alu_pkg;

   typedef enum logic [4:0] {
      C_ADD_U,
      C_SUB_U,
      C_AND,
      C_OR,
      C_XOR,
      C_SLL,
      C_SRL,
      C_SRA,
      C_SLT,
      C_SLT_U,
      C_PASS_A,
      C_PASS_B,
      C_MULT,
      C_MULT_U,
      C_BEQ,
      C_BNE,
      C_BLEZ,
      C_BGTZ,
      C_BLTZ,
      C_BGEZ
   } alu_sel_t;

   localparam logic [1:0] SEL_ALU_OUT = 2'd0;
   localparam logic [1:0] SEL_LO      = 2'd1;
   localparam logic [1:0] SEL_HI      = 2'd2;

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DONE
   } mul_state_t;

endpackage

// File: rtl/alu_exec_mult_seq.sv
// mult_seq: iterative shift-add multiplier, one partial product per cycle.
// Signed operands are multiplied as magnitudes and the product negated at DONE.
module mult_seq
   import alu_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic               is_signed,
   input  logic [WIDTH-1:0]   a,
   input  logic [WIDTH-1:0]   b,
   output logic               busy,
   output logic               done,
   output logic [2*WIDTH-1:0] product
);

   localparam int CW = $clog2(WIDTH);

   mul_state_t         state;
   logic [CW-1:0]      cnt;
   logic [WIDTH-1:0]   ma;
   logic [WIDTH-1:0]   mb;
   logic               neg;
   logic [2*WIDTH-1:0] acc;
   logic [WIDTH-1:0]   addend;
   logic [WIDTH:0]     sum;

   assign addend = mb[0] ? ma : '0;
   assign sum    = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, addend};

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= IDLE;
         cnt   <= '0;
         ma    <= '0;
         mb    <= '0;
         neg   <= 1'b0;
         acc   <= '0;
      end else begin
         unique case (state)
            IDLE: begin
               if (start) begin
                  ma    <= (is_signed && a[WIDTH-1]) ? -a : a;
                  mb    <= (is_signed && b[WIDTH-1]) ? -b : b;
                  neg   <= is_signed && (a[WIDTH-1] ^ b[WIDTH-1]);
                  acc   <= '0;
                  cnt   <= CW'(WIDTH - 1);
                  state <= RUN;
               end
            end
            RUN: begin
               // Right-shifting accumulator: carry-out of the high half enters at the top.
               acc <= {sum, acc[WIDTH-1:1]};
               mb  <= mb >> 1;
               cnt <= cnt - 1'b1;
               if (cnt == '0) state <= DONE;
            end
            DONE: state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

   assign busy    = (state != IDLE);
   assign done    = (state == DONE);
   assign product = neg ? -acc : acc;

endmodule

// File: rtl/alu_exec.sv
// alu_exec: execute stage with combinational ALU, branch compare,
// ALU_OUT/HI/LO registers and the registered-source output mux.
module alu_exec
   import alu_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  alu_sel_t         opsel,
   input  logic [WIDTH-1:0] in0,
   input  logic [WIDTH-1:0] in1,
   input  logic [4:0]       shamt,
   input  logic             hi_en,
   input  logic             lo_en,
   input  logic [1:0]       alu_lo_hi,
   output logic [WIDTH-1:0] result,
   output logic             branch_taken,
   output logic [WIDTH-1:0] alu_mux_out,
   output logic             busy,
   output logic             done
);

   logic [WIDTH-1:0]   alu_q;
   logic [WIDTH-1:0]   hi_q;
   logic [WIDTH-1:0]   lo_q;
   logic [2*WIDTH-1:0] product;
   logic               mul_start;
   logic               mul_signed;
   logic               a_neg;
   logic               a_zero;

   assign a_neg  = in0[WIDTH-1];
   assign a_zero = (in0 == '0);

   always_comb begin
      result = '0;
      unique case (opsel)
         C_ADD_U:  result = in0 + in1;
         C_SUB_U:  result = in0 - in1;
         C_AND:    result = in0 & in1;
         C_OR:     result = in0 | in1;
         C_XOR:    result = in0 ^ in1;
         C_SLL:    result = in1 << shamt;
         C_SRL:    result = in1 >> shamt;
         C_SRA:    result = WIDTH'($signed(in1) >>> shamt);
         C_SLT:    result = {{(WIDTH-1){1'b0}}, ($signed(in0) < $signed(in1))};
         C_SLT_U:  result = {{(WIDTH-1){1'b0}}, (in0 < in1)};
         C_PASS_A: result = in0;
         C_PASS_B: result = in1;
         default:  result = '0;
      endcase
   end

   always_comb begin
      branch_taken = 1'b0;
      unique case (opsel)
         C_BEQ:   branch_taken = (in0 == in1);
         C_BNE:   branch_taken = (in0 != in1);
         C_BLEZ:  branch_taken = a_neg || a_zero;
         C_BGTZ:  branch_taken = !a_neg && !a_zero;
         C_BLTZ:  branch_taken = a_neg;
         C_BGEZ:  branch_taken = !a_neg;
         default: branch_taken = 1'b0;
      endcase
   end

   // The multiplier only honours start while idle, so requests during busy drop.
   assign mul_signed = (opsel == C_MULT);
   assign mul_start  = en && ((opsel == C_MULT) || (opsel == C_MULT_U));

   mult_seq #(
      .WIDTH(WIDTH)
   ) u_mult (
      .clk      (clk),
      .rst      (rst),
      .start    (mul_start),
      .is_signed(mul_signed),
      .a        (in0),
      .b        (in1),
      .busy     (busy),
      .done     (done),
      .product  (product)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         alu_q <= '0;
         hi_q  <= '0;
         lo_q  <= '0;
      end else begin
         if (en) alu_q <= result;
         if (done && hi_en) hi_q <= product[2*WIDTH-1:WIDTH];
         if (done && lo_en) lo_q <= product[WIDTH-1:0];
      end
   end

   always_comb begin
      alu_mux_out = alu_q;
      unique case (alu_lo_hi)
         SEL_LO:  alu_mux_out = lo_q;
         SEL_HI:  alu_mux_out = hi_q;
         default: alu_mux_out = alu_q;
      endcase
   end

endmodule

// File: tb/tb_alu_exec.sv
// tb_alu_exec: directed and randomized checks of alu_exec against
// an arithmetic reference model of the ALU, branches and multiplier.
module tb_alu_exec;
   import alu_pkg::*;

   logic        clk;
   logic        rst;
   logic        en;
   alu_sel_t    opsel;
   logic [31:0] in0;
   logic [31:0] in1;
   logic [4:0]  shamt;
   logic        hi_en;
   logic        lo_en;
   logic [1:0]  alu_lo_hi;
   logic [31:0] result;
   logic        branch_taken;
   logic [31:0] alu_mux_out;
   logic        busy;
   logic        done;

   int n_cmp = 0;
   int n_bad = 0;

   logic [31:0] alu_m = '0;
   logic [31:0] hi_m  = '0;
   logic [31:0] lo_m  = '0;

   alu_exec #(.WIDTH(32)) dut (
      .clk         (clk),
      .rst         (rst),
      .en          (en),
      .opsel       (opsel),
      .in0         (in0),
      .in1         (in1),
      .shamt       (shamt),
      .hi_en       (hi_en),
      .lo_en       (lo_en),
      .alu_lo_hi   (alu_lo_hi),
      .result      (result),
      .branch_taken(branch_taken),
      .alu_mux_out (alu_mux_out),
      .busy        (busy),
      .done        (done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [31:0] ref_res(alu_sel_t op, logic [31:0] a,
                                           logic [31:0] b, logic [4:0] s);
      int sa = $signed(a);
      int sb = $signed(b);
      case (op)
         C_ADD_U:  return a + b;
         C_SUB_U:  return a - b;
         C_AND:    return a & b;
         C_OR:     return a | b;
         C_XOR:    return a ^ b;
         C_SLL:    return b << s;
         C_SRL:    return b >> s;
         C_SRA:    return 32'(sb >>> s);
         C_SLT:    return (sa < sb) ? 32'd1 : 32'd0;
         C_SLT_U:  return (a < b) ? 32'd1 : 32'd0;
         C_PASS_A: return a;
         C_PASS_B: return b;
         default:  return 32'd0;
      endcase
   endfunction

   function automatic logic ref_br(alu_sel_t op, logic [31:0] a, logic [31:0] b);
      int sa = $signed(a);
      case (op)
         C_BEQ:   return a == b;
         C_BNE:   return a != b;
         C_BLEZ:  return sa <= 0;
         C_BGTZ:  return sa > 0;
         C_BLTZ:  return sa < 0;
         C_BGEZ:  return sa >= 0;
         default: return 1'b0;
      endcase
   endfunction

   function automatic logic [63:0] ref_mul(bit sgn, logic [31:0] a, logic [31:0] b);
      longint          sa = $signed(a);
      longint          sb = $signed(b);
      longint unsigned ua = a;
      longint unsigned ub = b;
      if (sgn) return 64'(sa * sb);
      return ua * ub;
   endfunction

   task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Advance one clock; ALU_OUT model follows every enabled edge.
   task automatic tick();
      if (en && rst) alu_m = ref_res(opsel, in0, in1, shamt);
      @(posedge clk);
      #1;
   endtask

   task automatic check_regs(string tag);
      alu_lo_hi = SEL_LO;
      #1 chk({tag, "_lo"}, alu_mux_out, lo_m);
      alu_lo_hi = SEL_HI;
      #1 chk({tag, "_hi"}, alu_mux_out, hi_m);
      alu_lo_hi = SEL_ALU_OUT;
      #1 chk({tag, "_aluout"}, alu_mux_out, alu_m);
   endtask

   task automatic run_mult(string tag, alu_sel_t op, logic [31:0] a, logic [31:0] b,
                           logic hen, logic len, int second_at);
      int          cyc     = 0;
      int          ndone   = 0;
      int          donecyc = -1;
      logic [63:0] p;
      p     = ref_mul(op == C_MULT, a, b);
      opsel = op;
      in0   = a;
      in1   = b;
      hi_en = hen;
      lo_en = len;
      en    = 1'b1;
      tick();
      en = 1'b0;
      for (int k = 0; k < 200; k++) begin
         if (!busy) break;
         cyc++;
         if (done) begin
            ndone++;
            donecyc = cyc;
         end
         en = (cyc == second_at);
         tick();
         en = 1'b0;
      end
      chk({tag, "_busy_cycles"}, 64'(cyc), 64'd33);
      chk({tag, "_done_cycle"}, 64'(donecyc), 64'd33);
      chk({tag, "_done_count"}, 64'(ndone), 64'd1);
      if (hen) hi_m = p[63:32];
      if (len) lo_m = p[31:0];
      check_regs(tag);
   endtask

   initial begin
      alu_sel_t    ops[$];
      alu_sel_t    op;
      int          nd;
      logic [31:0] ra;
      logic [31:0] rb;

      ops = '{C_ADD_U, C_SUB_U, C_AND, C_OR, C_XOR, C_SLL, C_SRL, C_SRA,
              C_SLT, C_SLT_U, C_PASS_A, C_PASS_B, C_BEQ, C_BNE, C_BLEZ,
              C_BGTZ, C_BLTZ, C_BGEZ};
      rst       = 1'b0;
      en        = 1'b0;
      opsel     = C_ADD_U;
      in0       = '0;
      in1       = '0;
      shamt     = '0;
      hi_en     = 1'b0;
      lo_en     = 1'b0;
      alu_lo_hi = SEL_ALU_OUT;
      tick();
      tick();
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_done", 64'(done), 64'd0);
      check_regs("rst");
      rst = 1'b1;
      tick();

      opsel = C_ADD_U; in0 = 32'hFFFF_FFFF; in1 = 32'd2; en = 1'b1;
      #1 chk("add_wrap", result, 32'h1);
      tick();
      en = 1'b0;
      chk("add_aluout", alu_mux_out, 32'h1);

      opsel = C_SRA; in1 = 32'h8000_0000; shamt = 5'd4;
      #1 chk("sra", result, 32'hF800_0000);
      opsel = C_SRL;
      #1 chk("srl", result, 32'h0800_0000);
      opsel = C_SLL; shamt = 5'd0; in1 = 32'hDEAD_BEEF;
      #1 chk("sll_sh0", result, 32'hDEAD_BEEF);
      opsel = C_SLT; in0 = 32'hFFFF_FFFF; in1 = 32'd1;
      #1 chk("slt", result, 32'd1);
      opsel = C_SLT_U;
      #1 chk("slt_u", result, 32'd0);
      opsel = C_MULT;
      #1 chk("mult_result0", result, 32'd0);
      opsel = alu_sel_t'(5'd25);
      #1 chk("undef_result", result, 32'd0);
      chk("undef_branch", 64'(branch_taken), 64'd0);

      opsel = C_BEQ; in0 = 32'd5; in1 = 32'd5;
      #1 chk("beq", 64'(branch_taken), 64'd1);
      opsel = C_BNE;
      #1 chk("bne", 64'(branch_taken), 64'd0);
      opsel = C_BLEZ; in0 = 32'd0;
      #1 chk("blez0", 64'(branch_taken), 64'd1);
      opsel = C_BGEZ;
      #1 chk("bgez0", 64'(branch_taken), 64'd1);
      opsel = C_BGTZ; in0 = 32'h8000_0000;
      #1 chk("bgtz_min", 64'(branch_taken), 64'd0);
      opsel = C_ADD_U;
      #1 chk("add_nobranch", 64'(branch_taken), 64'd0);

      run_mult("mult_m3x7", C_MULT, 32'hFFFF_FFFD, 32'd7, 1'b1, 1'b1, 0);
      run_mult("multu_max", C_MULT_U, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b1, 5);
      run_mult("mult_min", C_MULT, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 1'b1, 0);
      run_mult("mult_noen", C_MULT, 32'd12345, 32'd678, 1'b0, 1'b0, 0);

      opsel = C_MULT_U; in0 = 32'h1234_5678; in1 = 32'h9ABC_DEF0;
      hi_en = 1'b1; lo_en = 1'b1; en = 1'b1;
      tick();
      en = 1'b0;
      repeat (10) tick();
      chk("abort_busy_pre", 64'(busy), 64'd1);
      rst = 1'b0;
      alu_m = '0; hi_m = '0; lo_m = '0;
      #1 chk("abort_busy", 64'(busy), 64'd0);
      chk("abort_done", 64'(done), 64'd0);
      check_regs("abort");
      tick();
      rst = 1'b1;
      nd = 0;
      for (int k = 0; k < 40; k++) begin
         if (done || busy) nd++;
         tick();
      end
      chk("abort_no_done", 64'(nd), 64'd0);
      check_regs("abort_after");
      run_mult("mult_fresh", C_MULT_U, 32'h1234_5678, 32'h9ABC_DEF0, 1'b1, 1'b1, 0);

      for (int i = 0; i < 120; i++) begin
         op    = ops[$urandom_range(0, ops.size() - 1)];
         opsel = op;
         in0   = $urandom;
         in1   = (i % 7 == 0) ? in0 : $urandom;
         shamt = 5'($urandom);
         en    = 1'b1;
         #1 chk("rnd_result", result, ref_res(op, in0, in1, shamt));
         chk("rnd_branch", 64'(branch_taken), 64'(ref_br(op, in0, in1)));
         tick();
         en = 1'b0;
         chk("rnd_aluout", alu_mux_out, alu_m);
      end

      for (int i = 0; i < 4; i++) begin
         ra = $urandom;
         rb = $urandom;
         run_mult("rnd_mul", (i % 2 == 0) ? C_MULT : C_MULT_U, ra, rb,
                  1'($urandom), 1'($urandom), 0);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
